pulse_period_meter: RTL and testbench

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

---
 rtl/pulse_period_meter.sv | 128 ++++++++++++
 tb/tb_pulse_period_meter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
`default_nettype none
// ============================================================================
// pulse_period_meter: measures rising-to-rising period and high time of an
// asynchronous input in clk_in cycles, with a sticky no-edge timeout.
// Revision: 1.0
// ============================================================================
module pulse_period_meter #(
  parameter int CNT_W          = 26,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic [7:0]       meas_cnt
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1, s2, s3;
  logic             rise;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] high_cnt, high_cnt_nx;
  logic [CNT_W-1:0] period_nx, high_nx;
  logic             valid_nx, timeout_nx;
  logic [7:0]       meas_nx;

  // Synchronizer runs independently of en so edge history stays current.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cnt        <= '0;
      high_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      meas_cnt   <= 8'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      high_cnt   <= high_cnt_nx;
      period_out <= period_nx;
      high_out   <= high_nx;
      valid      <= valid_nx;
      timeout    <= timeout_nx;
      meas_cnt   <= meas_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    high_cnt_nx = high_cnt;
    period_nx   = period_out;
    high_nx     = high_out;
    valid_nx    = 1'b0;
    timeout_nx  = timeout;
    meas_nx     = meas_cnt;

    if (!en) begin
      state_nx    = IDLE;
      cnt_nx      = '0;
      high_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx    = MEASURE;
            cnt_nx      = '0;
            high_cnt_nx = CNT_ONE;
          end
        end
        MEASURE: begin
          // The rise cycle itself closes the period, hence cnt+1; a rise
          // coinciding with the last timeout count still wins.
          if (rise) begin
            period_nx   = cnt + CNT_ONE;
            high_nx     = high_cnt;
            valid_nx    = 1'b1;
            meas_nx     = meas_cnt + 8'd1;
            timeout_nx  = 1'b0;
            cnt_nx      = '0;
            high_cnt_nx = CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            timeout_nx  = 1'b1;
            state_nx    = IDLE;
            cnt_nx      = '0;
            high_cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
            if (s2) begin
              high_cnt_nx = high_cnt + CNT_ONE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
`default_nettype none
// Bench for pulse_period_meter: directed waveforms, scoreboard-checked valid
// pulses plus direct checks of timeout, reset and enable behaviour.
module tb_pulse_period_meter;

  localparam int CNT_W = 8;
  localparam int TO    = 100;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             timeout;
  logic [7:0]       meas_cnt;

  pulse_period_meter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (en),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .timeout    (timeout),
    .meas_cnt   (meas_cnt)
  );

  always #10 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] period;
    logic [7:0] high;
    logic [7:0] meas;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_meas;
  int         prev_p;
  int         prev_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'b0, valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_period", period_out, e.period);
          check("sb_high", high_out, e.high);
          check("sb_meas", meas_cnt, e.meas);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One period of p cycles, high for h; exp_valid marks that the rise
  // opening this period closes a measurement of the previous one.
  task automatic cyc(input int p, input int h, input bit exp_valid);
    for (int k = 0; k < p; k++) begin
      @(negedge clk_in);
      if (k == 0 && exp_valid) begin
        exp_meas = exp_meas + 8'd1;
        sb.push_back({8'(prev_p), 8'(prev_h), exp_meas});
      end
      sig_in = (k < h);
    end
    prev_p = p;
    prev_h = h;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period_out, 0);
    check({tag, "_high"}, high_out, 0);
    check({tag, "_valid"}, {31'b0, valid}, 0);
    check({tag, "_timeout"}, {31'b0, timeout}, 0);
    check({tag, "_meas"}, meas_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_in   = 1'b1;
    en       = 1'b0;
    sig_in   = 1'b0;
    exp_meas = 8'd0;
    prev_p   = 0;
    prev_h   = 0;
    fork
      monitor();
    join_none

    ticks(3);
    check_zero("reset");
    rst_in = 1'b0;
    en     = 1'b1;
    ticks(2);

    // 10/5 square wave, then duty change to 10/2
    cyc(10, 5, 1'b0);
    repeat (3) cyc(10, 5, 1'b1);
    cyc(10, 2, 1'b1);
    cyc(10, 2, 1'b1);

    // signal stops low: timeout exactly 100 cycles after the last rise
    ticks(93);
    check("timeout_early", {31'b0, timeout}, 0);
    ticks(1);
    check("timeout_set", {31'b0, timeout}, 1);
    check("timeout_period_hold", period_out, 10);
    check("timeout_high_hold", high_out, 2);
    check("timeout_meas_hold", meas_cnt, exp_meas);

    cyc(10, 5, 1'b0);
    check("timeout_after_rise1", {31'b0, timeout}, 1);
    cyc(10, 5, 1'b1);
    check("timeout_after_rise2", {31'b0, timeout}, 0);

    // period of exactly TIMEOUT_CYCLES: rise beats the timeout
    cyc(100, 50, 1'b1);
    cyc(10, 5, 1'b1);
    check("boundary_timeout", {31'b0, timeout}, 0);

    // reset mid-period
    ticks(2);
    rst_in = 1'b1;
    ticks(2);
    check_zero("mid_reset");
    rst_in   = 1'b0;
    exp_meas = 8'd0;
    ticks(3);
    check_zero("post_reset");
    cyc(10, 5, 1'b0);
    cyc(10, 5, 1'b1);

    // enable dropped for 50 cycles
    en = 1'b0;
    repeat (5) cyc(10, 5, 1'b0);
    check("en_low_period_hold", period_out, 10);
    check("en_low_meas_hold", meas_cnt, exp_meas);
    en = 1'b1;
    cyc(10, 5, 1'b0);
    cyc(10, 5, 1'b1);
    ticks(5);

    check("sb_pending", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
